// File: rtl/regread_arbiter.sv
// Round-robin arbiter sharing one register-file read mux among N_REQ requesters.
// Optional: define REGREAD_ARB_PRIORITY_EN to make requester 0 a preempting high-priority reader.
module regread_arbiter #(
    parameter int N_REQ    = 4,
    parameter int WIDTH    = 64,
    parameter int MAX_LOCK = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [N_REQ-1:0]      req,
    input  logic [N_REQ-1:0]      lock,
    input  logic [N_REQ-1:0][4:0] addr,
    output logic [4:0]            mux_sel,
    input  logic [WIDTH-1:0]      mux_out,
    output logic [N_REQ-1:0]      gnt,
    output logic [WIDTH-1:0]      rdata,
    output logic                  rvalid,
    output logic [2:0]            rid
);

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int LW = $clog2(MAX_LOCK + 1);

    typedef enum logic [1:0] {IDLE, GRANT, LOCKED} state_t;

    state_t           state_q, state_d;
    logic [IW-1:0]    ptr_q, ptr_d;
    logic [IW-1:0]    win_q, win_d;
    logic [LW-1:0]    lcnt_q, lcnt_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [4:0]       mux_sel_q, mux_sel_d;
    logic [WIDTH-1:0] rdata_q, rdata_d;
    logic             rvalid_q, rvalid_d;
    logic [2:0]       rid_q, rid_d;
    logic             active, keep, found;
    logic [IW-1:0]    idx;

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        win_d     = win_q;
        lcnt_d    = lcnt_q;
        gnt_d     = '0;
        mux_sel_d = mux_sel_q;
        found     = 1'b0;
        idx       = '0;

        active = (state_q != IDLE);
        keep   = active && req[win_q] && lock[win_q] && (lcnt_q < LW'(MAX_LOCK));
`ifdef REGREAD_ARB_PRIORITY_EN
        if (req[0] && (win_q != '0)) begin
            keep = 1'b0;
        end
`endif

        if (keep) begin
            found   = 1'b1;
            win_d   = win_q;
            lcnt_d  = lcnt_q + 1'b1;
            state_d = LOCKED;
        end else begin
            if (active) begin
                ptr_d = (win_q == IW'(N_REQ - 1)) ? '0 : win_q + 1'b1;
            end
`ifdef REGREAD_ARB_PRIORITY_EN
            // Requester 0 never advances or disturbs the rotation of the others.
            if (req[0] || (active && (win_q == '0))) begin
                ptr_d = ptr_q;
            end
`endif
            // Searching from the owner's successor excludes it unless it is alone.
            for (int k = 0; k < N_REQ; k++) begin
                idx = IW'((int'(ptr_d) + k) % N_REQ);
                if (!found && req[idx]) begin
                    found = 1'b1;
                    win_d = idx;
                end
            end
`ifdef REGREAD_ARB_PRIORITY_EN
            if (req[0]) begin
                found = 1'b1;
                win_d = '0;
            end
`endif
            if (found) begin
                lcnt_d  = LW'(1);
                state_d = GRANT;
            end else begin
                lcnt_d  = '0;
                state_d = IDLE;
            end
        end

        if (found) begin
            gnt_d[win_d] = 1'b1;
            mux_sel_d    = addr[win_d];
        end

        rvalid_d = active;
        rdata_d  = active ? mux_out : rdata_q;
        rid_d    = active ? 3'(win_q) : rid_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            win_q     <= '0;
            lcnt_q    <= '0;
            gnt_q     <= '0;
            mux_sel_q <= '0;
            rdata_q   <= '0;
            rvalid_q  <= 1'b0;
            rid_q     <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            win_q     <= win_d;
            lcnt_q    <= lcnt_d;
            gnt_q     <= gnt_d;
            mux_sel_q <= mux_sel_d;
            rdata_q   <= rdata_d;
            rvalid_q  <= rvalid_d;
            rid_q     <= rid_d;
        end
    end

    assign gnt     = gnt_q;
    assign mux_sel = mux_sel_q;
    assign rdata   = rdata_q;
    assign rvalid  = rvalid_q;
    assign rid     = rid_q;

endmodule

// File: tb/tb_regread_arbiter.sv
// Scoreboard bench for regread_arbiter in its default pure round-robin build.
module tb_regread_arbiter;

    localparam int N_REQ    = 4;
    localparam int WIDTH    = 64;
    localparam int MAX_LOCK = 8;

    typedef struct packed {
        logic [2:0]       id;
        logic [WIDTH-1:0] data;
    } rd_t;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [N_REQ-1:0]      req;
    logic [N_REQ-1:0]      lock;
    logic [N_REQ-1:0][4:0] addr;
    logic [4:0]            mux_sel;
    logic [WIDTH-1:0]      mux_out;
    logic [N_REQ-1:0]      gnt;
    logic [WIDTH-1:0]      rdata;
    logic                  rvalid;
    logic [2:0]            rid;

    logic [WIDTH-1:0] mem [32];
    rd_t              expQ[$];
    logic             pendRead;
    int               errorCount = 0;
    int               checkCount = 0;

    regread_arbiter #(.N_REQ(N_REQ), .WIDTH(WIDTH), .MAX_LOCK(MAX_LOCK)) dut (
        .clk(clk), .reset(reset), .req(req), .lock(lock), .addr(addr),
        .mux_sel(mux_sel), .mux_out(mux_out), .gnt(gnt),
        .rdata(rdata), .rvalid(rvalid), .rid(rid)
    );

    always #5 clk = ~clk;

    // The register file's read mux is modelled as a plain array lookup.
    assign mux_out = mem[mux_sel];

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
        end
    endtask

    // Drives one cycle, checks the read returned for the previous grant, then this cycle's grant.
    task automatic applyStimulus(input logic [3:0] r, input logic [3:0] l, input logic [3:0] expGnt);
        rd_t e;
        int  w;
        req  = r;
        lock = l;
        @(posedge clk);
        #1;
        checkOutput("rvalid", 64'(rvalid), 64'(pendRead));
        if (pendRead && expQ.size() > 0) begin
            e = expQ.pop_front();
            if (rvalid) begin
                checkOutput("rid", 64'(rid), 64'(e.id));
                checkOutput("rdata", rdata, e.data);
            end
        end
        checkOutput("gnt", 64'(gnt), 64'(expGnt));
        pendRead = (expGnt != 4'b0000);
        if (pendRead) begin
            w = 0;
            for (int i = 0; i < N_REQ; i++) begin
                if (expGnt[i]) w = i;
            end
            checkOutput("mux_sel", 64'(mux_sel), 64'(addr[w]));
            expQ.push_back('{id: 3'(w), data: mem[addr[w]]});
        end
    endtask

    task automatic resetDut();
        reset = 1'b1;
        req   = '0;
        lock  = '0;
        #1;
        checkOutput("rst_gnt", 64'(gnt), 64'(0));
        checkOutput("rst_mux_sel", 64'(mux_sel), 64'(0));
        checkOutput("rst_rvalid", 64'(rvalid), 64'(0));
        checkOutput("rst_rdata", rdata, 64'(0));
        checkOutput("rst_rid", 64'(rid), 64'(0));
        @(posedge clk);
        #1;
        reset    = 1'b0;
        pendRead = 1'b0;
        expQ.delete();
    endtask

    initial begin
        reset    = 1'b0;
        req      = '0;
        lock     = '0;
        addr     = '0;
        pendRead = 1'b0;
        for (int i = 0; i < 32; i++) mem[i] = 64'(i);
        #3;

        $display("[TB] reset then single read");
        resetDut();
        addr[0] = 5'd5;
        applyStimulus(4'b0001, 4'b0000, 4'b0001);
        applyStimulus(4'b0000, 4'b0000, 4'b0000);
        applyStimulus(4'b0000, 4'b0000, 4'b0000);

        $display("[TB] round robin, all requesting");
        resetDut();
        for (int i = 0; i < N_REQ; i++) addr[i] = 5'(i + 8);
        applyStimulus(4'b1111, 4'b0000, 4'b0001);
        applyStimulus(4'b1111, 4'b0000, 4'b0010);
        applyStimulus(4'b1111, 4'b0000, 4'b0100);
        applyStimulus(4'b1111, 4'b0000, 4'b1000);
        applyStimulus(4'b1111, 4'b0000, 4'b0001);
        applyStimulus(4'b0000, 4'b0000, 4'b0000);
        applyStimulus(4'b0101, 4'b0000, 4'b0100);
        applyStimulus(4'b0101, 4'b0000, 4'b0001);
        applyStimulus(4'b0000, 4'b0000, 4'b0000);

        $display("[TB] lock limit with a competitor");
        resetDut();
        for (int i = 0; i < MAX_LOCK; i++) applyStimulus(4'b0011, 4'b0001, 4'b0001);
        applyStimulus(4'b0011, 4'b0001, 4'b0010);
        applyStimulus(4'b0011, 4'b0001, 4'b0001);
        applyStimulus(4'b0000, 4'b0000, 4'b0000);

        $display("[TB] lock limit with a lone requester");
        resetDut();
        for (int i = 0; i < MAX_LOCK + 1; i++) applyStimulus(4'b0001, 4'b0001, 4'b0001);
        for (int i = 0; i < MAX_LOCK - 1; i++) applyStimulus(4'b0011, 4'b0001, 4'b0001);
        applyStimulus(4'b0011, 4'b0001, 4'b0010);
        applyStimulus(4'b0000, 4'b0000, 4'b0000);

        $display("[TB] reset during a grant");
        resetDut();
        applyStimulus(4'b0010, 4'b0000, 4'b0010);
        applyStimulus(4'b0100, 4'b0000, 4'b0100);
        resetDut();
        applyStimulus(4'b0000, 4'b0000, 4'b0000);
        applyStimulus(4'b1111, 4'b0000, 4'b0001);
        applyStimulus(4'b0000, 4'b0000, 4'b0000);

        $display("[TB] data sweep, threshold pattern");
        resetDut();
        for (int i = 0; i < 32; i++) mem[i] = 64'(i > 15);
        for (int a = 0; a < 32; a++) begin
            addr[1] = 5'(a);
            applyStimulus(4'b0010, 4'b0000, 4'b0010);
        end
        applyStimulus(4'b0000, 4'b0000, 4'b0000);

        $display("[TB] data sweep, random pattern");
        for (int i = 0; i < 32; i++) mem[i] = {$urandom, $urandom};
        for (int a = 31; a >= 0; a--) begin
            addr[1] = 5'(a);
            addr[3] = 5'(31 - a);
            applyStimulus(4'b0010, 4'b0000, 4'b0010);
        end
        applyStimulus(4'b0000, 4'b0000, 4'b0000);
        applyStimulus(4'b0000, 4'b0000, 4'b0000);

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
